// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD layer arbiter.
package lcd_pkg;

    localparam int COORD_W = 10;

    typedef logic [15:0]        rgb565_t;
    typedef logic [COORD_W-1:0] coord_t;

    // Configuration field codes carried on CFG_FIELD.
    localparam logic [2:0] FLD_X0    = 3'd0;
    localparam logic [2:0] FLD_Y0    = 3'd1;
    localparam logic [2:0] FLD_X1    = 3'd2;
    localparam logic [2:0] FLD_Y1    = 3'd3;
    localparam logic [2:0] FLD_COLOR = 3'd4;
    localparam logic [2:0] FLD_EN    = 3'd5;
    localparam logic [2:0] FLD_BG    = 3'd6;
    localparam logic [2:0] FLD_RSVD  = 3'd7;

    // One rectangle layer: half-open box [x0,x1) x [y0,y1).
    typedef struct packed {
        coord_t  x0;
        coord_t  y0;
        coord_t  x1;
        coord_t  y1;
        rgb565_t color;
        logic    en;
    } layer_t;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } commit_state_t;

    // Apply a single per-layer field write; BG and reserved codes leave the layer untouched.
    function automatic layer_t layer_write(input layer_t cur,
                                           input logic [2:0] field,
                                           input logic [15:0] data);
        layer_t nxt;
        nxt = cur;
        case (field)
            FLD_X0:    nxt.x0    = data[COORD_W-1:0];
            FLD_Y0:    nxt.y0    = data[COORD_W-1:0];
            FLD_X1:    nxt.x1    = data[COORD_W-1:0];
            FLD_Y1:    nxt.y1    = data[COORD_W-1:0];
            FLD_COLOR: nxt.color = data;
            FLD_EN:    nxt.en    = data[0];
            default:   nxt       = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_rect_hit.sv
// Combinational beam-position test against one rectangle layer.
module lcd_rect_hit
    import lcd_pkg::*;
(
    input  coord_t XPOS,
    input  coord_t YPOS,
    input  layer_t LAYER,
    output logic   HIT
);

    // Half-open compare; x1<=x0 or y1<=y0 can never satisfy both bounds, so empty boxes never hit.
    assign HIT = LAYER.en
              && (XPOS >= LAYER.x0) && (XPOS < LAYER.x1)
              && (YPOS >= LAYER.y0) && (YPOS < LAYER.y1);

endmodule

// File: rtl/lcd_layer_arbiter.sv
// Rectangle-layer pixel source with shadow/active configuration and frame-aligned commit.
module lcd_layer_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
)
(
    input  logic               LCD_CLK,
    input  logic               RESET,
    input  logic [9:0]         XPOS,
    input  logic [9:0]         YPOS,
    input  logic               DEN,
    input  logic               VSYNC,
    input  logic               CFG_VALID,
    output logic               CFG_READY,
    input  logic [LAYER_W-1:0] CFG_LAYER,
    input  logic [2:0]         CFG_FIELD,
    input  logic [15:0]        CFG_DATA,
    input  logic               CFG_COMMIT,
    output logic               COMMIT_DONE,
    output logic [15:0]        PIXEL,
    output logic               PIXEL_DEN,
    output logic [15:0]        FRAME_COUNT
);

    layer_t        shadow [NUM_LAYERS];
    layer_t        active [NUM_LAYERS];
    rgb565_t       shadow_bg;
    rgb565_t       active_bg;

    logic          vsync_r;
    logic          vsync_rr;
    logic          frame_start;
    logic [15:0]   frame_cnt;

    commit_state_t state;
    commit_state_t state_nxt;
    logic          accept;
    logic          copy_en;

    logic [NUM_LAYERS-1:0] hit_raw;
    logic [NUM_LAYERS-1:0] hit_p1;
    logic                  vld_p1;
    rgb565_t               pix_sel;

    assign accept      = CFG_VALID && CFG_READY;
    assign frame_start = vsync_rr && !vsync_r;
    assign FRAME_COUNT = frame_cnt;

    // VSYNC history; idles high so leaving reset with VSYNC high is not a frame start.
    always_ff @(posedge LCD_CLK or posedge RESET) begin
        if (RESET) begin
            vsync_r  <= 1'b1;
            vsync_rr <= 1'b1;
        end else begin
            vsync_r  <= VSYNC;
            vsync_rr <= vsync_r;
        end
    end

    // Frame counter, free-running and wrapping.
    always_ff @(posedge LCD_CLK or posedge RESET) begin
        if (RESET) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Commit state register.
    always_ff @(posedge LCD_CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Commit next-state and handshake outputs; a frame start seen in IDLE never copies.
    always_comb begin
        state_nxt   = state;
        CFG_READY   = 1'b0;
        COMMIT_DONE = 1'b0;
        copy_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                CFG_READY = 1'b1;
                if (CFG_VALID && CFG_COMMIT) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    COMMIT_DONE = 1'b1;
                    copy_en     = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shadow writes; out-of-range layers and the reserved field fall through untouched.
    always_ff @(posedge LCD_CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow[i] <= '0;
            end
            shadow_bg <= '0;
        end else if (accept) begin
            if (CFG_FIELD == FLD_BG) begin
                shadow_bg <= CFG_DATA;
            end else if (CFG_FIELD != FLD_RSVD) begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    if (CFG_LAYER == LAYER_W'(i)) begin
                        shadow[i] <= layer_write(shadow[i], CFG_FIELD, CFG_DATA);
                    end
                end
            end
        end
    end

    // Active set only ever changes on the frame-start cycle of a pending commit.
    always_ff @(posedge LCD_CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                active[i] <= '0;
            end
            active_bg <= '0;
        end else if (copy_en) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                active[i] <= shadow[i];
            end
            active_bg <= shadow_bg;
        end
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_hit
        lcd_rect_hit u_hit (
            .XPOS  (XPOS),
            .YPOS  (YPOS),
            .LAYER (active[g]),
            .HIT   (hit_raw[g])
        );
    end

    // ---- stage 1: per-layer hit vector and data enable ----
    always_ff @(posedge LCD_CLK or posedge RESET) begin
        if (RESET) begin
            hit_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            hit_p1 <= hit_raw;
            vld_p1 <= DEN;
        end
    end

    // Priority select: scan high to low so the lowest-index hit wins.
    always_comb begin
        pix_sel = active_bg;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit_p1[i]) begin
                pix_sel = active[i].color;
            end
        end
    end

    // ---- stage 2: blanked pixel output ----
    always_ff @(posedge LCD_CLK or posedge RESET) begin
        if (RESET) begin
            PIXEL     <= '0;
            PIXEL_DEN <= 1'b0;
        end else begin
            PIXEL     <= vld_p1 ? pix_sel : 16'h0000;
            PIXEL_DEN <= vld_p1;
        end
    end

endmodule

// File: tb/tb_lcd_layer_arbiter.sv
// Directed bench for lcd_layer_arbiter with hand-computed expectations.
module tb_lcd_layer_arbiter;
    import lcd_pkg::*;

    logic        LCD_CLK = 1'b0;
    logic        RESET;
    logic [9:0]  XPOS;
    logic [9:0]  YPOS;
    logic        DEN;
    logic        VSYNC;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [1:0]  CFG_LAYER;
    logic [2:0]  CFG_FIELD;
    logic [15:0] CFG_DATA;
    logic        CFG_COMMIT;
    logic        COMMIT_DONE;
    logic [15:0] PIXEL;
    logic        PIXEL_DEN;
    logic [15:0] FRAME_COUNT;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int d;

    always #5 LCD_CLK = ~LCD_CLK;

    lcd_layer_arbiter #(.NUM_LAYERS(4)) dut (
        .LCD_CLK     (LCD_CLK),
        .RESET       (RESET),
        .XPOS        (XPOS),
        .YPOS        (YPOS),
        .DEN         (DEN),
        .VSYNC       (VSYNC),
        .CFG_VALID   (CFG_VALID),
        .CFG_READY   (CFG_READY),
        .CFG_LAYER   (CFG_LAYER),
        .CFG_FIELD   (CFG_FIELD),
        .CFG_DATA    (CFG_DATA),
        .CFG_COMMIT  (CFG_COMMIT),
        .COMMIT_DONE (COMMIT_DONE),
        .PIXEL       (PIXEL),
        .PIXEL_DEN   (PIXEL_DEN),
        .FRAME_COUNT (FRAME_COUNT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge LCD_CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] layer, input logic [2:0] field, input logic [15:0] data);
        CFG_LAYER = layer;
        CFG_FIELD = field;
        CFG_DATA  = data;
        CFG_VALID = 1'b1;
        tick();
        CFG_VALID = 1'b0;
    endtask

    task automatic set_layer(input logic [1:0] l, input logic [15:0] x0, input logic [15:0] y0,
                             input logic [15:0] x1, input logic [15:0] y1,
                             input logic [15:0] color, input logic [15:0] en);
        cfg_write(l, FLD_X0, x0);
        cfg_write(l, FLD_Y0, y0);
        cfg_write(l, FLD_X1, x1);
        cfg_write(l, FLD_Y1, y1);
        cfg_write(l, FLD_COLOR, color);
        cfg_write(l, FLD_EN, en);
    endtask

    // Commit carries the reserved field so the accompanying write is discarded.
    task automatic commit();
        CFG_FIELD  = FLD_RSVD;
        CFG_DATA   = 16'hDEAD;
        CFG_VALID  = 1'b1;
        CFG_COMMIT = 1'b1;
        tick();
        CFG_VALID  = 1'b0;
        CFG_COMMIT = 1'b0;
    endtask

    task automatic frame(output int dones);
        dones = 0;
        VSYNC = 1'b0;
        repeat (3) begin
            tick();
            if (COMMIT_DONE) dones++;
        end
        VSYNC = 1'b1;
        repeat (2) begin
            tick();
            if (COMMIT_DONE) dones++;
        end
        exp_frames++;
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [15:0] exp, input string tag);
        XPOS = x;
        YPOS = y;
        DEN  = 1'b1;
        tick();
        tick();
        check(tag, 32'(PIXEL), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [9:0] pat;
        RESET = 1'b1; VSYNC = 1'b1; DEN = 1'b0; XPOS = '0; YPOS = '0;
        CFG_VALID = 1'b0; CFG_COMMIT = 1'b0; CFG_LAYER = '0; CFG_FIELD = '0; CFG_DATA = '0;
        repeat (3) tick();
        check("rst_ready", 32'(CFG_READY), 32'd1);
        check("rst_done",  32'(COMMIT_DONE), 32'd0);
        check("rst_pixel", 32'(PIXEL), 32'd0);
        check("rst_pden",  32'(PIXEL_DEN), 32'd0);
        check("rst_fcnt",  32'(FRAME_COUNT), 32'd0);
        RESET = 1'b0;
        tick();

        // Unconfigured: black pixels, DEN delayed two cycles.
        pat = 10'b1011001101;
        for (int i = 0; i < 10; i++) begin
            XPOS = 10'(i * 61);
            YPOS = 10'(i * 47);
            DEN  = pat[i];
            tick();
            if (i >= 1) check("den_lat", 32'(PIXEL_DEN), 32'(pat[i-1]));
            check("unconf_pix", 32'(PIXEL), 32'd0);
        end

        // Single layer, commit, boundaries.
        set_layer(2'd0, 16'd100, 16'd100, 16'd200, 16'd200, 16'hFFFF, 16'd1);
        commit();
        check("pend_ready", 32'(CFG_READY), 32'd0);
        probe(10'd150, 10'd150, 16'h0000, "pre_commit");
        frame(d);
        check("done_once", 32'(d), 32'd1);
        check("ready_back", 32'(CFG_READY), 32'd1);
        check("fcnt1", 32'(FRAME_COUNT), 32'(exp_frames));
        probe(10'd150, 10'd150, 16'hFFFF, "l0_in");
        probe(10'd199, 10'd199, 16'hFFFF, "l0_corner");
        probe(10'd200, 10'd150, 16'h0000, "l0_x1_excl");
        probe(10'd99,  10'd150, 16'h0000, "l0_x0_left");
        XPOS = 10'd150; YPOS = 10'd150; DEN = 1'b0;
        tick(); tick();
        check("den0_pix",  32'(PIXEL), 32'd0);
        check("den0_pden", 32'(PIXEL_DEN), 32'd0);

        // Overlap priority and background.
        set_layer(2'd0, 16'd0, 16'd0, 16'd100, 16'd100, 16'hF81F, 16'd1);
        set_layer(2'd1, 16'd40, 16'd40, 16'd80, 16'd80, 16'h07E0, 16'd1);
        cfg_write(2'd0, FLD_BG, 16'h001F);
        commit();
        frame(d);
        check("done_ov", 32'(d), 32'd1);
        probe(10'd50,  10'd50,  16'hF81F, "ov_l0_wins");
        probe(10'd90,  10'd90,  16'hF81F, "ov_l0_only");
        probe(10'd150, 10'd150, 16'h001F, "ov_bg");
        probe(10'd100, 10'd50,  16'h001F, "ov_x1_excl");
        cfg_write(2'd0, FLD_EN, 16'd0);
        commit();
        probe(10'd50, 10'd50, 16'hF81F, "dis_before");
        frame(d);
        probe(10'd50, 10'd50, 16'h07E0, "dis_l1");
        probe(10'd90, 10'd90, 16'h001F, "dis_bg");

        // Mid-frame shadow write and write while pending.
        cfg_write(2'd0, FLD_EN, 16'd1);
        commit();
        frame(d);
        probe(10'd50, 10'd50, 16'hF81F, "reen");
        cfg_write(2'd0, FLD_COLOR, 16'h1234);
        probe(10'd50, 10'd50, 16'hF81F, "shadow_only");
        commit();
        check("pend_ready2", 32'(CFG_READY), 32'd0);
        cfg_write(2'd0, FLD_COLOR, 16'hABCD);
        check("pend_ready3", 32'(CFG_READY), 32'd0);
        probe(10'd50, 10'd50, 16'hF81F, "pend_hold");
        frame(d);
        check("done_mid", 32'(d), 32'd1);
        probe(10'd50, 10'd50, 16'h1234, "new_color");

        // Commit accepted in the frame-start cycle waits a whole frame.
        cfg_write(2'd0, FLD_COLOR, 16'h5555);
        VSYNC = 1'b0;
        tick();
        check("fs_done_idle", 32'(COMMIT_DONE), 32'd0);
        CFG_FIELD = FLD_RSVD; CFG_VALID = 1'b1; CFG_COMMIT = 1'b1;
        tick();
        CFG_VALID = 1'b0; CFG_COMMIT = 1'b0;
        check("fs_pending", 32'(CFG_READY), 32'd0);
        d = 0;
        repeat (2) begin tick(); if (COMMIT_DONE) d++; end
        VSYNC = 1'b1;
        repeat (2) begin tick(); if (COMMIT_DONE) d++; end
        exp_frames++;
        check("fs_no_copy", 32'(d), 32'd0);
        check("fs_fcnt", 32'(FRAME_COUNT), 32'(exp_frames));
        probe(10'd50, 10'd50, 16'h1234, "fs_old");
        frame(d);
        check("fs_next_done", 32'(d), 32'd1);
        probe(10'd50, 10'd50, 16'h5555, "fs_new");

        // Reset while pending discards the commit.
        cfg_write(2'd0, FLD_COLOR, 16'h7777);
        commit();
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        exp_frames = 0;
        check("rp_ready", 32'(CFG_READY), 32'd1);
        check("rp_done",  32'(COMMIT_DONE), 32'd0);
        check("rp_fcnt",  32'(FRAME_COUNT), 32'd0);
        tick();
        frame(d);
        check("rp_no_done", 32'(d), 32'd0);
        probe(10'd50, 10'd50, 16'h0000, "rp_active0");

        // Empty rectangle never hits; next layer still visible.
        set_layer(2'd0, 16'd300, 16'd0, 16'd300, 16'd480, 16'hFFFF, 16'd1);
        set_layer(2'd1, 16'd300, 16'd0, 16'd301, 16'd200, 16'h07E0, 16'd1);
        commit();
        frame(d);
        probe(10'd300, 10'd100, 16'h07E0, "empty_skip");
        probe(10'd301, 10'd100, 16'h0000, "empty_bg");

        // Frame counter wrap.
        force dut.frame_cnt = 16'hFFFE;
        tick();
        release dut.frame_cnt;
        tick();
        check("wrap_pre", 32'(FRAME_COUNT), 32'h0000FFFE);
        frame(d);
        check("wrap_ffff", 32'(FRAME_COUNT), 32'h0000FFFF);
        frame(d);
        check("wrap_zero", 32'(FRAME_COUNT), 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
